// File: rtl/z_pwm_pkg.sv
// Shared constants and helpers for the z_pwm PWM generator.
package z_pwm_pkg;

  localparam int unsigned DEF_WIDTH  = 32'd20;
  localparam int unsigned DEF_PERIOD = 32'd1000000;
  localparam int unsigned DEF_INC    = 32'd20;

  // Enabled clocks per PWM period: ceil(period / inc).
  function automatic int unsigned period_clks(input int unsigned period, input int unsigned inc);
    if (inc == 32'd0) begin
      return 32'd0;
    end else begin
      return (period + inc - 32'd1) / inc;
    end
  endfunction

endpackage

// File: rtl/z_pwm_cnt.sv
// Period counter for z_pwm: advances by pINC per enabled clock and wraps to 0
// once the next value would reach pPERIOD, flagging the wrap on end_tick.
module z_pwm_cnt
  import z_pwm_pkg::*;
#(
  parameter int unsigned pWIDTH  = DEF_WIDTH,
  parameter int unsigned pPERIOD = DEF_PERIOD,
  parameter int unsigned pINC    = DEF_INC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic [pWIDTH-1:0] cnt,
  output logic              end_tick
);

  localparam logic [pWIDTH:0] INC_EXT = pINC[pWIDTH:0];
  localparam logic [pWIDTH:0] PER_EXT = pPERIOD[pWIDTH:0];

  logic [pWIDTH-1:0] cnt_q, cnt_d;
  logic              tick_q, tick_d;
  logic [pWIDTH:0]   sum_s;

  // Next count; the sum carries one extra bit so it cannot overflow.
  always_comb begin
    sum_s  = {1'b0, cnt_q} + INC_EXT;
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (en) begin
      if (sum_s >= PER_EXT) begin
        cnt_d  = '0;
        tick_d = 1'b1;
      end else begin
        cnt_d  = sum_s[pWIDTH-1:0];
        tick_d = 1'b0;
      end
    end else begin
      cnt_d  = cnt_q;
      tick_d = 1'b0;
    end
  end

  // Counter and wrap-pulse registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign cnt      = cnt_q;
  assign end_tick = tick_q;

endmodule

// File: rtl/z_pwm.sv
// z_pwm top: period counter plus registered duty comparator.
// Define ZPWM_DUTY_LATCH_EN to sample cyc_duty only at period boundaries.
module z_pwm
  import z_pwm_pkg::*;
#(
  parameter int unsigned pWIDTH  = DEF_WIDTH,
  parameter int unsigned pPERIOD = DEF_PERIOD,
  parameter int unsigned pINC    = DEF_INC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [pWIDTH-1:0] cyc_duty,
  output logic              end_tick,
  output logic              wave
);

  if ((pINC == 32'd0) || (64'(pPERIOD) >= (64'd1 << pWIDTH))) begin : g_bad_cfg
    $fatal(1, "z_pwm: pINC must be nonzero and pPERIOD must fit in pWIDTH bits");
  end

  logic [pWIDTH-1:0] cnt_s;
  logic [pWIDTH-1:0] duty_eff_s;
  logic              wave_q, wave_d;

  z_pwm_cnt #(
    .pWIDTH (pWIDTH),
    .pPERIOD(pPERIOD),
    .pINC   (pINC)
  ) u_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .cnt     (cnt_s),
    .end_tick(end_tick)
  );

`ifdef ZPWM_DUTY_LATCH_EN
  localparam logic [pWIDTH:0] INC_EXT = pINC[pWIDTH:0];
  localparam logic [pWIDTH:0] PER_EXT = pPERIOD[pWIDTH:0];

  logic [pWIDTH-1:0] duty_q, duty_d;
  logic [pWIDTH:0]   sum_s;
  logic              wrap_s;

  // Capture the duty on the edge that wraps, so the whole new period uses it.
  always_comb begin
    sum_s  = {1'b0, cnt_s} + INC_EXT;
    wrap_s = en & (sum_s >= PER_EXT);
    if (wrap_s) begin
      duty_d = cyc_duty;
    end else begin
      duty_d = duty_q;
    end
  end

  // Latched duty register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      duty_q <= '0;
    end else begin
      duty_q <= duty_d;
    end
  end

  assign duty_eff_s = duty_q;
`else
  assign duty_eff_s = cyc_duty;
`endif

  // Comparator; gating with en forces the output low while paused.
  always_comb begin
    wave_d = en & (cnt_s < duty_eff_s);
  end

  // Registered PWM output.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wave_q <= 1'b0;
    end else begin
      wave_q <= wave_d;
    end
  end

  assign wave = wave_q;

endmodule

// File: tb/tb_z_pwm.sv
// Scoreboard bench for z_pwm: two instances (divisible and non-divisible
// increment) checked against a period-position reference model.
module tb_z_pwm;
  import z_pwm_pkg::*;

  localparam int P     = 100;
  localparam int INC_A = 10;
  localparam int INC_B = 30;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] cyc_duty;
  logic       tick_a, wave_a, tick_b, wave_b;

  typedef struct {
    logic tick;
    logic wave;
    int   cnt;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   k[2];
  int   dlat[2];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  z_pwm #(.pWIDTH(8), .pPERIOD(P), .pINC(INC_A)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .cyc_duty(cyc_duty),
    .end_tick(tick_a), .wave(wave_a)
  );

  z_pwm #(.pWIDTH(8), .pPERIOD(P), .pINC(INC_B)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .cyc_duty(cyc_duty),
    .end_tick(tick_b), .wave(wave_b)
  );

  // Model: k = enabled clocks elapsed in the current period, cnt = k*inc.
  function automatic exp_t model_step(int i, int inc);
    exp_t e;
    int   ncl;
    int   duty;
    ncl = (P + inc - 1) / inc;
    if (!rst_n) begin
      k[i]    = 0;
      dlat[i] = 0;
      e.tick  = 1'b0;
      e.wave  = 1'b0;
    end else if (en) begin
`ifdef ZPWM_DUTY_LATCH_EN
      duty = dlat[i];
`else
      duty = int'(cyc_duty);
`endif
      e.wave = (k[i] * inc < duty);
      k[i]   = k[i] + 1;
      if (k[i] == ncl) begin
        k[i]    = 0;
        e.tick  = 1'b1;
        dlat[i] = int'(cyc_duty);
      end else begin
        e.tick = 1'b0;
      end
    end else begin
      e.tick = 1'b0;
      e.wave = 1'b0;
    end
    e.cnt = k[i] * inc;
    return e;
  endfunction

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  always @(posedge clk) begin
    q_a.push_back(model_step(0, INC_A));
    q_b.push_back(model_step(1, INC_B));
  end

  always @(negedge clk) begin
    exp_t e;
    if (q_a.size() > 0) begin
      e = q_a.pop_front();
      chk("tick_a", {31'd0, tick_a}, {31'd0, e.tick});
      chk("wave_a", {31'd0, wave_a}, {31'd0, e.wave});
      chk("cnt_a", {24'd0, u_dut_a.cnt_s}, e.cnt);
    end
    if (q_b.size() > 0) begin
      e = q_b.pop_front();
      chk("tick_b", {31'd0, tick_b}, {31'd0, e.tick});
      chk("wave_b", {31'd0, wave_b}, {31'd0, e.wave});
      chk("cnt_b", {24'd0, u_dut_b.cnt_s}, e.cnt);
    end
  end

  task automatic hold(int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n    = 1'b0;
    en       = 1'b0;
    cyc_duty = 8'd0;
    hold(3);
    rst_n    = 1'b1;
    en       = 1'b1;
    cyc_duty = 8'd30;
    hold(25);
    cyc_duty = 8'd50;
    hold(14);
    en = 1'b0;
    hold(5);
    en = 1'b1;
    hold(20);
    cyc_duty = 8'd0;
    hold(20);
    cyc_duty = 8'd255;
    hold(20);
    cyc_duty = 8'd100;
    hold(12);
    cyc_duty = 8'd99;
    hold(12);
    cyc_duty = 8'd30;
    hold(14);
    cyc_duty = 8'd70;
    hold(25);
    rst_n = 1'b0;
    hold(1);
    rst_n = 1'b1;
    hold(25);
    for (int s = 0; s < 400; s++) begin
      case ($urandom_range(0, 5))
        0:       cyc_duty = 8'd0;
        1:       cyc_duty = 8'd100;
        2:       cyc_duty = 8'd99;
        3:       cyc_duty = 8'd255;
        default: cyc_duty = 8'($urandom_range(0, 255));
      endcase
      en    = ($urandom_range(0, 4) != 0);
      rst_n = ($urandom_range(0, 24) != 0);
      hold($urandom_range(1, 12));
    end
    rst_n = 1'b1;
    en    = 1'b1;
    hold(4);
    @(posedge clk);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/z_pwm.md
Z_PWM -- requirements
Module: z_pwm

Interface
REQ-001 The block SHALL have parameter pWIDTH, default 20, giving the width of the counter and the duty input in bits.
REQ-002 The block SHALL have parameter pPERIOD, default 1000000, giving the PWM period in counter units (ns when pINC = ns per clock).
REQ-003 The block SHALL have parameter pINC, default 20, giving the counter increment per enabled clock.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 The block SHALL have port en, input, 1 bit: count enable.
REQ-007 The block SHALL have port cyc_duty, input, pWIDTH bits: high time per period, in counter units.
REQ-008 The block SHALL have port end_tick, output, 1 bit: one-cycle pulse at period wrap.
REQ-009 The block SHALL have port wave, output, 1 bit: PWM output.

Function
REQ-010 The block SHALL hold an internal counter cnt, pWIDTH bits, and SHALL evaluate cnt+pINC at pWIDTH+1 bits so the sum never overflows.
REQ-011 With en=1, when cnt+pINC >= pPERIOD, the block SHALL load cnt with 0 and set end_tick=1 for exactly that next cycle.
REQ-012 With en=1, when cnt+pINC < pPERIOD, the block SHALL load cnt with cnt+pINC and set end_tick=0.
REQ-013 The period SHALL therefore be ceil(pPERIOD/pINC) enabled clocks, including when pINC does not divide pPERIOD.
REQ-014 With en=0, cnt SHALL hold, end_tick SHALL be 0 and wave SHALL be 0; counting resumes from the held value when en returns to 1.
REQ-015 wave SHALL be registered: wave <= en AND (cnt < duty_eff), giving one cycle of latency from cnt.
REQ-016 cyc_duty = 0 SHALL give constant wave=0.
REQ-017 cyc_duty >= pPERIOD SHALL give constant wave=1 while en=1.
REQ-018 Elaboration SHALL fail if pINC = 0 or pPERIOD >= 2**pWIDTH.

Reset
REQ-019 When rst_n=0 at a clock edge, the block SHALL set cnt=0, end_tick=0, wave=0 and duty_q=0; reset SHALL take priority over en.
REQ-020 Reset asserted mid-period SHALL discard the partial period, and the first period after release SHALL start at cnt=0.

Configuration
REQ-021 With macro ZPWM_DUTY_LATCH_EN defined, duty_eff SHALL be a register duty_q loaded from cyc_duty on each wrap cycle (the cycle in which end_tick is set), so duty changes take effect only at the next period boundary.
REQ-022 With ZPWM_DUTY_LATCH_EN undefined, duty_eff SHALL be cyc_duty directly, so changes affect wave immediately, and there SHALL be no duty_q register.

Structure
REQ-023 A shared package z_pwm_pkg SHALL hold the default parameter constants and a helper function computing the period length in clocks for benches.
REQ-024 The counter/wrap logic SHALL be a sub-module z_pwm_cnt with outputs cnt and end_tick.
REQ-025 The top level SHALL hold the duty latch and the comparator.

Verification
REQ-026 Basic PWM (pWIDTH=8, pPERIOD=100, pINC=10, en=1, cyc_duty=30): end_tick SHALL pulse every 10 clocks, and wave SHALL be high 3 of each 10 clocks.
REQ-027 Non-divisible increment (pPERIOD=100, pINC=30): cnt SHALL follow 0,30,60,90,0; end_tick SHALL pulse every 4 clocks; with cyc_duty=50, wave SHALL be high 2 of 4 clocks.
REQ-028 Duty extremes: cyc_duty=0 SHALL give wave always 0; cyc_duty=255 SHALL give wave always 1; end_tick SHALL be unaffected.
REQ-029 Enable gating: dropping en for 5 clocks mid-period SHALL freeze cnt, hold wave=0 and end_tick=0, and extend that period by exactly 5 clocks.
REQ-030 Reset mid-period: rst_n=0 for one edge at cnt=50 SHALL give cnt=0, wave=0 and end_tick=0 next cycle, and the next wrap SHALL occur 10 clocks after release.
REQ-031 Latch (ZPWM_DUTY_LATCH_EN defined): changing cyc_duty 30->70 mid-period SHALL leave the high time at 3 for the current period and make it 7 from the next period; with the macro undefined, the change SHALL apply at once.
